// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and parameter helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clock cycles per bit, truncating.
  function automatic int unsigned calc_baud_clk(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // True when the frame format and bit period are supported.
  function automatic bit params_ok(input int unsigned baud_clk,
                                   input int unsigned data_bits,
                                   input int unsigned parity,
                                   input int unsigned stop_bits);
    return (baud_clk >= 2) && (data_bits >= 5) && (data_bits <= 9) &&
           (parity <= 2) && (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: one-cycle tick every BAUD_CLK cycles, restartable by clear.
module uart_baud_gen #(
  parameter int unsigned BAUD_CLK = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = $clog2(BAUD_CLK);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CNT_W'(BAUD_CLK - 1));

  // Count 0..BAUD_CLK-1; clear restarts the period with no phase carry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: configurable data bits, parity and stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PARAM = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA_IN,
  input  logic                 VALID,
  output logic                 READY,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned BAUD_CLK = calc_baud_clk(CLK_PARAM, BAUD_RATE);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  if (!params_ok(BAUD_CLK, DATA_BITS, PARITY, STOP_BITS)) begin : g_param_err
    $error("uart_tx_cfg: illegal parameter combination");
  end

  state_t               r_state, w_state_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [IDX_W-1:0]     r_idx, w_idx_n;
  logic                 r_par, w_par_n;
  logic                 r_tx, w_tx_n;
  logic                 r_busy;
  logic                 r_done, w_done_n;
  logic                 w_accept;
  logic                 w_tick;

  assign READY    = (r_state == ST_IDLE) && !RST;
  assign w_accept = VALID && READY;
  assign TX       = r_tx;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

  uart_baud_gen #(
    .BAUD_CLK (BAUD_CLK)
  ) u_baud_gen (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clr    (w_accept),
    .o_tick_c (w_tick)
  );

  // Next-state logic; w_tx_n is the line level for the following cycle.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_par_n   = r_par;
    w_tx_n    = 1'b1;
    w_done_n  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_n = ST_START;
          w_shift_n = DATA_IN;
          w_idx_n   = '0;
          w_par_n   = (PARITY == PAR_EVEN) ? ^DATA_IN : ~^DATA_IN;
          w_tx_n    = 1'b0;
        end
      end
      ST_START: begin
        w_tx_n = 1'b0;
        if (w_tick) begin
          w_state_n = ST_DATA;
          w_tx_n    = r_shift[0];
        end
      end
      ST_DATA: begin
        w_tx_n = r_shift[0];
        if (w_tick) begin
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_idx_n = '0;
            if (PARITY != PAR_NONE) begin
              w_state_n = ST_PARITY;
              w_tx_n    = r_par;
            end else begin
              w_state_n = ST_STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_idx_n   = r_idx + IDX_W'(1);
            w_shift_n = r_shift >> 1;
            w_tx_n    = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        w_tx_n = r_par;
        if (w_tick) begin
          w_state_n = ST_STOP;
          w_tx_n    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_idx == IDX_W'(STOP_BITS - 1)) begin
            w_state_n = ST_IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_idx_n = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset forces the line idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_idx   <= w_idx_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_busy  <= (w_state_n != ST_IDLE);
      r_done  <= w_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: 8N1, 7E2 and 8O1 instances on one clock.
module tb_uart_tx_cfg;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int          BCLK   = 10;

  localparam int DB  [3] = '{8, 7, 8};
  localparam int PAR [3] = '{0, 2, 1};
  localparam int SB  [3] = '{1, 2, 1};
  localparam int OFF [3] = '{0, 8, 15};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid;
  logic [22:0] data_bus;
  logic [2:0]  ready;
  logic [2:0]  tx;
  logic [2:0]  busy;
  logic [2:0]  done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_PARAM(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
  u_8n1 (.CLK(clk), .RST(rst), .DATA_IN(data_bus[7:0]), .VALID(valid[0]),
         .READY(ready[0]), .TX(tx[0]), .BUSY(busy[0]), .DONE(done[0]));

  uart_tx_cfg #(.CLK_PARAM(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
  u_7e2 (.CLK(clk), .RST(rst), .DATA_IN(data_bus[14:8]), .VALID(valid[1]),
         .READY(ready[1]), .TX(tx[1]), .BUSY(busy[1]), .DONE(done[1]));

  uart_tx_cfg #(.CLK_PARAM(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
  u_8o1 (.CLK(clk), .RST(rst), .DATA_IN(data_bus[22:15]), .VALID(valid[2]),
         .READY(ready[2]), .TX(tx[2]), .BUSY(busy[2]), .DONE(done[2]));

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic set_data(input int k, input logic [8:0] d);
    for (int b = 0; b < DB[k]; b++) data_bus[OFF[k] + b] = d[b];
  endtask

  // Expected line level per clock cycle of one frame, from the frame format.
  task automatic build_frame(input int k, input logic [8:0] d);
    int ones;
    bit p;
    ones = 0;
    exp_q.delete();
    repeat (BCLK) exp_q.push_back(1'b0);
    for (int b = 0; b < DB[k]; b++) begin
      ones += int'(d[b]);
      repeat (BCLK) exp_q.push_back(d[b]);
    end
    if (PAR[k] != 0) begin
      p = (PAR[k] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      repeat (BCLK) exp_q.push_back(p);
    end
    repeat (SB[k] * BCLK) exp_q.push_back(1'b1);
  endtask

  task automatic start(input int k, input logic [8:0] d);
    @(negedge clk);
    set_data(k, d);
    valid[k] = 1'b1;
    chk($sformatf("ready_before_send[%0d]", k), ready[k], 1'b1);
    @(posedge clk);
  endtask

  // Check a frame cycle by cycle, then the DONE/READY cycle that follows it.
  task automatic run_frame(input int k, input logic [8:0] d, input bit keep_valid,
                           input logic [8:0] next_d, input bit pulse);
    build_frame(k, d);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0 && !keep_valid) valid[k] = 1'b0;
      if (i == exp_q.size() / 2) set_data(k, 9'($urandom));
      if (pulse && i == 30) valid[k] = 1'b1;
      if (pulse && i == 32) valid[k] = 1'b0;
      chk($sformatf("tx[%0d] d=%0h cyc=%0d", k, d, i), tx[k], exp_q[i]);
      chk($sformatf("busy[%0d] cyc=%0d", k, i), busy[k], 1'b1);
      chk($sformatf("ready[%0d] cyc=%0d", k, i), ready[k], 1'b0);
      chk($sformatf("done_early[%0d] cyc=%0d", k, i), done[k], 1'b0);
    end
    @(negedge clk);
    if (keep_valid) set_data(k, next_d);
    chk($sformatf("done_pulse[%0d]", k), done[k], 1'b1);
    chk($sformatf("ready_at_done[%0d]", k), ready[k], 1'b1);
    chk($sformatf("tx_gap[%0d]", k), tx[k], 1'b1);
    chk($sformatf("busy_at_done[%0d]", k), busy[k], 1'b0);
  endtask

  task automatic idle_check(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      chk($sformatf("idle_done[%0d]", k), done[k], 1'b0);
      chk($sformatf("idle_tx[%0d]", k), tx[k], 1'b1);
      chk($sformatf("idle_busy[%0d]", k), busy[k], 1'b0);
      chk($sformatf("idle_ready[%0d]", k), ready[k], 1'b1);
    end
  endtask

  initial begin
    logic [8:0] d;
    rst      = 1'b1;
    valid    = '0;
    data_bus = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_tx[%0d]", k), tx[k], 1'b1);
      chk($sformatf("rst_busy[%0d]", k), busy[k], 1'b0);
      chk($sformatf("rst_done[%0d]", k), done[k], 1'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst[%0d]", k), ready[k], 1'b1);

    // Directed frames from the three formats
    start(0, 9'h0A5); run_frame(0, 9'h0A5, 1'b0, 9'h0, 1'b0); idle_check(0, 3);
    start(1, 9'h041); run_frame(1, 9'h041, 1'b0, 9'h0, 1'b0); idle_check(1, 3);
    start(2, 9'h000); run_frame(2, 9'h000, 1'b0, 9'h0, 1'b0); idle_check(2, 3);

    // VALID held high: back-to-back frames one idle cycle apart
    start(0, 9'h055);
    run_frame(0, 9'h055, 1'b1, 9'h0AA, 1'b0);
    run_frame(0, 9'h0AA, 1'b0, 9'h0, 1'b0);
    idle_check(0, 3);

    // VALID pulsed while busy is ignored
    d = 9'($urandom);
    start(0, d); run_frame(0, d, 1'b0, 9'h0, 1'b1); idle_check(0, 12);

    // Asynchronous reset mid-frame (data bit 2 is low there)
    start(0, 9'h03B);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (36) @(negedge clk);
    chk("tx_low_before_rst", tx[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx[0], 1'b1);
    chk("rst_mid_busy", busy[0], 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", done[0], 1'b0);
      chk("rst_hold_tx", tx[0], 1'b1);
    end
    rst = 1'b0;
    idle_check(0, 3);
    start(0, 9'h03C); run_frame(0, 9'h03C, 1'b0, 9'h0, 1'b0); idle_check(0, 2);

    // Random words on every format
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        d = 9'($urandom);
        start(k, d);
        run_frame(k, d, 1'b0, 9'h0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one word per valid/ready handshake onto the TX line. Data width, parity mode and stop-bit count are compile-time parameters, and the block reports frame completion. It sits between a byte or word source (FIFO, CPU register) and the board TX pin, and shares a baud generator with the future receiver.

## Interface
- CLK_PARAM, 50000000: input clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits/s.
- DATA_BITS, 8: data bits per frame, legal range 5–9.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- BAUD_CLK (localparam): CLK_PARAM / BAUD_RATE, integer truncation. Must be ≥ 2; elaboration error otherwise.
- CLK  input  1  single system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- DATA_IN  input  DATA_BITS  word to send; sampled only on handshake.
- VALID  input  1  source has a word on DATA_IN.
- READY  output  1  block can accept a word this cycle.
- TX  output  1  serial line, idle high, registered.
- BUSY  output  1  frame in progress.
- DONE  output  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX=1, READY=1, BUSY=0.
- Handshake: a word is accepted on a rising edge where VALID && READY. On that edge:
  - DATA_IN is latched into the shift register.
  - The baud counter is cleared.
  - The bit index is cleared.
  - State goes to START.
- VALID outside IDLE is ignored; no queueing. DATA_IN changes after acceptance have no effect.
- START: TX=0 for BAUD_CLK cycles, then DATA.
- DATA: bits are sent LSB first. Each bit is held BAUD_CLK cycles. After bit DATA_BITS-1, go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - Even: TX = XOR of the latched data.
  - Odd: TX = XNOR of the latched data.
  - Held BAUD_CLK cycles, then STOP.
- STOP: TX=1 for STOP_BITS×BAUD_CLK cycles, then IDLE.
- DONE is asserted in the first IDLE cycle after STOP.
- BUSY=1 in every non-IDLE state. READY = (state==IDLE).
- Baud counter: width $clog2(BAUD_CLK). It counts 0..BAUD_CLK-1, and the bit advances when the count reaches BAUD_CLK-1. It wraps to 0 with no phase carry between frames.
- Illegal parameter values (DATA_BITS outside 5–9, PARITY>2, STOP_BITS outside 1–2) are elaboration errors.

## Timing
- Reset values: TX=1, BUSY=0, DONE=0, state IDLE, so READY=1 once RST is low.
- RST asserted mid-frame:
  - TX goes to 1 immediately (asynchronous), BUSY to 0.
  - The frame is aborted and no DONE is produced.
  - No handshake is taken while RST=1.
- Latency: TX goes low in the cycle after the accepting edge.
- Frame length is exactly BAUD_CLK×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles of non-idle TX.
- DONE and READY=1 coincide in the same cycle. If VALID is high then, the next word is accepted on that edge.
- Minimum inter-frame gap is one CLK cycle of TX=1 beyond the stop bits.
- All outputs are registered except READY, which is decoded from registered state.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - a function for the BAUD_CLK computation and range check.
- Sub-module uart_baud_gen: counter with a clear input. It emits a one-cycle tick every BAUD_CLK cycles and will be reused by the receiver.
- The top holds the FSM, shift register, bit index and parity logic.

## Test plan
All tests use CLK_PARAM=1000000 and BAUD_RATE=100000, so BAUD_CLK=10.
- 8N1, DATA_IN=0xA5 → TX runs 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. BUSY is high for 100 cycles, then DONE pulses once.
- 7E2, DATA_IN=0x41 → 7 data bits 1,0,0,0,0,0,1, parity bit 0, two stop bits. Frame is 110 cycles.
- 8O1, DATA_IN=0x00 → parity bit 1. Frame is 110 cycles.
- 8N1, VALID held high with 0x55 then 0xAA → both frames are correct, separated by exactly 1 idle-high cycle. A DATA_IN change mid-frame does not alter the TX pattern.
- VALID pulsed during BUSY → ignored. No second frame, READY stays 0 until IDLE.
- RST asserted at cycle 37 of a frame → TX=1 and BUSY=0 in the same cycle, no DONE. After release, READY=1 and a new 0x3C frame is correct.
